// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a valid/ready request port and a fixed-latency
// response port; misaligned or out-of-range requests return an error without touching storage.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam int unsigned CW       = (CNT_INIT > 1) ? $clog2(CNT_INIT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            op_write;
  logic [31:0]     op_addr;
  logic [31:0]     op_wdata;
  logic            op_err;
  logic [AW-1:0]   op_idx;
  logic            commit;
  logic            mem_we;

  // With LATENCY=1 the access happens on the acceptance edge, so use the live request.
  always_comb begin
    op_write = (state_q == IDLE) ? req_write : write_q;
    op_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    op_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    op_err   = (op_addr[1:0] != 2'b00) || (op_addr[31:AW+2] != '0);
    op_idx   = op_addr[AW+1:2];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            commit = 1'b1;
          end else begin
            state_d     = WAIT;
            cnt_d       = CW'(CNT_INIT);
            req_ready_d = 1'b0;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          req_ready_d  = 1'b1;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Memory access and response capture on the edge that enters RESP.
    if (commit) begin
      state_d      = RESP;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b1;
      resp_err_d   = op_err;
      resp_rdata_d = '0;
      if (!op_err) begin
        if (op_write) begin
          mem_we = 1'b1;
        end else begin
          resp_rdata_d = mem_q[op_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage is never cleared; a reset edge suppresses a store that would commit on it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem_q[op_idx] <= op_wdata;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 instance for functional/boundary/reset cases,
// LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1 = 1'b0, req_write1 = 1'b0, resp_ready1 = 1'b1;
  logic [31:0] req_addr1 = '0, req_wdata1 = '0;
  logic        req_ready1, resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // One request on the LATENCY=2 instance; optional backpressure window with a stray request.
  task automatic do_req(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err, input int hold);
    int lat;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    wait_ready();
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    if (hold > 0) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h40;
      req_wdata = 32'h0;
      for (int h = 0; h < hold; h++) begin
        tick();
        check({tag, "_bp_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_bp_rdata"}, resp_rdata, exp_rd);
        check({tag, "_bp_err"}, 32'(resp_err), 32'(exp_err));
        check({tag, "_bp_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_rdy_after"}, 32'(req_ready), 32'd1);
    check({tag, "_vld_after"}, 32'(resp_valid), 32'd0);
  endtask

  // Acceptance/handshake recorder for the LATENCY=1 instance.
  int          cyc = 0;
  int          acc_q[$];
  int          hs_q[$];
  logic [31:0] rd_q[$];

  always @(posedge clk) begin
    if (!rst) begin
      if (req_valid1 && req_ready1) acc_q.push_back(cyc);
      if (resp_valid1 && resp_ready1) begin
        hs_q.push_back(cyc);
        rd_q.push_back(resp_rdata1);
      end
      cyc++;
    end
  end

  logic        l1_w[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] l1_a[4]  = '{32'h20, 32'h20, 32'h24, 32'h24};
  logic [31:0] l1_d[4]  = '{32'hA5A5_0001, 32'h0, 32'h0000_BEEF, 32'h0};

  initial begin
    // Reset behaviour
    tick();
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(req_ready), 32'd1);

    // Store then load, read-after-write
    do_req("st40", 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
    do_req("ld40", 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Misalignment
    do_req("ld42", 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 0);
    do_req("st41", 1'b1, 32'h41, 32'h1, 32'h0, 1'b1, 0);
    do_req("ld40b", 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Range boundary and no aliasing
    do_req("st0", 1'b1, 32'h0, 32'h0000_1111, 32'h0, 1'b0, 0);
    do_req("st3fc", 1'b1, 32'h3FC, 32'h0000_CAFE, 32'h0, 1'b0, 0);
    do_req("st400", 1'b1, 32'h400, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    do_req("ld400", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 0);
    do_req("ld0", 1'b0, 32'h0, 32'h0, 32'h0000_1111, 1'b0, 0);
    do_req("ld3fc", 1'b0, 32'h3FC, 32'h0, 32'h0000_CAFE, 1'b0, 0);

    // Backpressure with a stray store that must be ignored
    do_req("bp", 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);
    do_req("ld40c", 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

    // Reset in WAIT drops a pending store
    do_req("st8", 1'b1, 32'h8, 32'h0BAD_0008, 32'h0, 1'b0, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h8;
    req_wdata = 32'h1234_5678;
    wait_ready();
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rw_resp_valid", 32'(resp_valid), 32'd0);
    check("rw_resp_rdata", resp_rdata, 32'd0);
    check("rw_resp_err", 32'(resp_err), 32'd0);
    check("rw_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("rw_ready_after", 32'(req_ready), 32'd1);
    do_req("ld8", 1'b0, 32'h8, 32'h0, 32'h0BAD_0008, 1'b0, 0);

    // Reset in RESP keeps a committed store
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'hC;
    req_wdata = 32'h0000_0077;
    wait_ready();
    tick();
    req_valid = 1'b0;
    tick();
    check("rr_in_resp", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rr_resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    tick();
    do_req("ldc", 1'b0, 32'hC, 32'h0, 32'h0000_0077, 1'b0, 0);

    // LATENCY=1 back-to-back with resp_ready tied high
    for (int i = 0; i < 4; i++) begin
      int n;
      req_valid1 = 1'b1;
      req_write1 = l1_w[i];
      req_addr1  = l1_a[i];
      req_wdata1 = l1_d[i];
      n = 0;
      while (!req_ready1 && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) check("l1_ready_timeout", 32'(req_ready1), 32'd1);
      tick();
    end
    req_valid1 = 1'b0;
    repeat (4) tick();

    check("l1_acc_count", 32'(acc_q.size()), 32'd4);
    check("l1_hs_count", 32'(hs_q.size()), 32'd4);
    if (acc_q.size() == 4 && hs_q.size() == 4) begin
      for (int i = 1; i < 4; i++) check("l1_acc_gap", 32'(acc_q[i] - acc_q[i-1]), 32'd2);
      for (int i = 0; i < 4; i++) check("l1_resp_lat", 32'(hs_q[i] - acc_q[i]), 32'd1);
      check("l1_ld20", rd_q[1], 32'hA5A5_0001);
      check("l1_ld24", rd_q[3], 32'h0000_BEEF);
      check("l1_st_rdata", rd_q[0], 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Parameters
REQ-001 DEPTH_WORDS, default 256, is the number of 32-bit storage words and SHALL be a power of two, at least 4.
REQ-002 LATENCY, default 2, is the number of cycles from request acceptance to resp_valid and SHALL be at least 1.

Interface
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  initiator has a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_write  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  initiator consumes the response.
REQ-012 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-013 resp_err  output  1  request was misaligned or out of range.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; it is 0 in WAIT and RESP.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata are latched at that edge.
REQ-017 On acceptance the FSM SHALL go IDLE -> WAIT when LATENCY>1, or IDLE -> RESP when LATENCY=1.
REQ-018 WAIT SHALL use a down-counter so that resp_valid first reads 1 exactly LATENCY cycles after the acceptance edge.
REQ-019 The word index SHALL be latched_addr[log2(DEPTH_WORDS)+1:2].
REQ-020 Error condition: latched_addr[1:0]!=0, or latched_addr >= 4*DEPTH_WORDS.
REQ-021 On error the block SHALL NOT access the array, and SHALL drive resp_err=1 and resp_rdata=0.
REQ-022 A valid store SHALL write the array on the edge that enters RESP, with resp_rdata=0 and resp_err=0.
REQ-023 A valid load SHALL capture array[index] into resp_rdata on the edge that enters RESP, with resp_err=0.
REQ-024 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1 is sampled.
REQ-025 On the RESP handshake edge the FSM SHALL return to IDLE, so req_ready is 1 on the next cycle.
REQ-026 Maximum throughput SHALL be one request per LATENCY+1 cycles.
REQ-027 req_valid, req_addr and other request inputs SHALL be ignored outside IDLE.
REQ-028 resp_ready SHALL be ignored outside RESP.
REQ-029 A load that follows a store to the same address SHALL return the stored value (read-after-write).
REQ-030 Address wrap-around SHALL NOT occur: out-of-range addresses raise resp_err and are never aliased.

Reset
REQ-031 With rst=1 at a rising edge, the next state SHALL be IDLE and the WAIT counter SHALL be 0.
REQ-032 Outputs after a reset edge: req_ready=0 while rst=1, then 1; resp_valid=0, resp_rdata=0, resp_err=0.
REQ-033 Array contents SHALL NOT be cleared by reset.
REQ-034 Reset asserted in WAIT SHALL discard the pending request; a pending store SHALL NOT modify the array.
REQ-035 Reset asserted in RESP SHALL drop the response; an already committed store SHALL remain in the array.

Verification
REQ-036 Store then load, LATENCY=2: store 0xDEADBEEF to 0x40, then load 0x40 -> each resp_valid exactly 2 cycles after acceptance; the load returns 0xDEADBEEF with resp_err=0.
REQ-037 Misaligned load at 0x42 -> resp_err=1 and resp_rdata=0; a misaligned store at 0x41 of 0x1 leaves word 0x40 unchanged.
REQ-038 Load at 0x400 with DEPTH=256 -> resp_err=1; a load of 0x0 is unaffected (no aliasing).
REQ-039 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; a new req_valid in that window is not accepted.
REQ-040 Reset one cycle after accepting a store of 0x12345678 to 0x8 -> IDLE with outputs 0; a later load of 0x8 returns the prior contents.
REQ-041 With LATENCY=1 and back-to-back requests with resp_ready tied to 1 -> an acceptance every 2 cycles and resp_valid 1 cycle after each acceptance.
